rr_arbiter: RTL
===============

RR_ARBITER -- requirements
Module: rr_arbiter

Interface
REQ-001 The module SHALL have parameter WIDTH_LOG, default 2, giving N = 1 << WIDTH_LOG requesters; legal range 1..7.
REQ-002 The module SHALL have parameter MAX_HOLD, default 16, giving the maximum grant tenure in cycles; legal range 2..255.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 The module SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The module SHALL have port req  input  N  request vector; bit i high = requester i wants the shared resource.
REQ-006 The module SHALL have port done  input  1  single-cycle pulse from the resource: current owner finished.
REQ-007 The module SHALL have port gnt  output  N  one-hot grant vector, registered.
REQ-008 The module SHALL have port gnt_idx  output  8  binary index of the granted requester, zero-extended, registered.
REQ-009 The module SHALL have port gnt_valid  output  1  high while a grant is held, registered.
REQ-010 The module SHALL have port timeout  output  1  single-cycle pulse: grant revoked after MAX_HOLD cycles without done.

Function
REQ-011 The module SHALL implement a two-state FSM: IDLE (no grant) and BUSY (grant held).
REQ-012 The module SHALL keep an internal priority pointer ptr (WIDTH_LOG bits); requester ptr has highest priority.
REQ-013 Winner selection SHALL be: lowest index i >= ptr with req[i] high; if none, lowest index i < ptr with req[i] high.
REQ-014 IDLE with req != 0 at edge k SHALL load gnt, gnt_idx, gnt_valid=1 visible after edge k, and enter BUSY (1-cycle latency).
REQ-015 IDLE with req == 0 SHALL stay IDLE with gnt=0, gnt_valid=0, gnt_idx holding its last value.
REQ-016 In BUSY, gnt and gnt_idx SHALL remain constant regardless of req changes, including the owner deasserting its req bit.
REQ-017 In BUSY, a hold counter SHALL count cycles from 1 (first BUSY cycle) upward, saturating never beyond MAX_HOLD.
REQ-018 BUSY with done=1 SHALL clear gnt and gnt_valid at the next edge, set ptr = (gnt_idx + 1) mod N, clear the counter, and return to IDLE.
REQ-019 BUSY with done=0 and counter == MAX_HOLD SHALL do the same as REQ-018 and additionally assert timeout for exactly that one following cycle.
REQ-020 If done=1 and counter == MAX_HOLD coincide, done SHALL win; timeout SHALL stay 0.
REQ-021 After leaving BUSY the module SHALL spend at least one cycle in IDLE (gnt_valid=0) before any new grant; back-to-back grants are separated by one idle cycle.
REQ-022 done while in IDLE SHALL be ignored with no state, pointer or output change.
REQ-023 ptr wrap SHALL be modular: owner N-1 releasing yields ptr=0.
REQ-024 gnt SHALL always be either all-zero or exactly one-hot, and gnt[gnt_idx] SHALL equal gnt_valid.
REQ-025 The winner computation SHALL be purely combinational from req and ptr; only FSM state, ptr, counter and outputs are registers.

Reset
REQ-026 rst_n low SHALL immediately (asynchronously) force state=IDLE, ptr=0, counter=0, gnt=0, gnt_idx=0, gnt_valid=0, timeout=0.
REQ-027 Reset asserted mid-BUSY SHALL drop the grant at once; a pending timeout pulse SHALL be cancelled.
REQ-028 The first edge after rst_n rises SHALL behave as IDLE with ptr=0.

Verification (N=4, MAX_HOLD=8)
REQ-029 Single requester: req=4'b0100 after reset -> next cycle gnt=4'b0100, gnt_idx=2, gnt_valid=1; done pulse -> next cycle gnt=0, ptr=3.
REQ-030 Round-robin fairness: req=4'b1111 held, done pulsed every grant -> grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-031 Pointer wrap: ptr=3, req=4'b0011 -> grant to 0; after done, ptr=1, req=4'b0011 -> grant to 1.
REQ-032 Timeout: req=4'b0001, no done -> gnt_valid high for exactly 8 cycles, then gnt=0 and timeout=1 for one cycle, ptr=1.
REQ-033 Coincidence and ignore: done on 8th BUSY cycle -> release with timeout=0; done pulse in IDLE -> no change; owner drops req mid-BUSY -> grant held.
REQ-034 Async reset: rst_n pulled low between edges during BUSY -> all outputs 0 before next edge; after release, req=4'b1000 -> grant to 3 from ptr=0.

Source files
------------

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//
// Round-robin arbiter with a bounded grant tenure. One requester at a time is
// given ownership of a shared resource. The owner keeps its grant until the
// resource signals completion with a single-cycle 'done' pulse, or until
// MAX_HOLD cycles have gone by without one. In the second case the grant is
// revoked and 'timeout' pulses for one cycle. After every release the priority
// pointer moves to the requester just after the previous owner, so every
// active requester is served in turn.
//
// Parameters
//   WIDTH_LOG  log2 of the requester count N (1..7)
//   MAX_HOLD   maximum grant tenure in cycles (2..255)
//
// Ports
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        [N-1:0] request vector, bit i = requester i wants the resource
//   done       single-cycle pulse from the resource: the owner has finished
//   gnt        [N-1:0] registered grant, all-zero or one-hot
//   gnt_idx    [7:0] registered binary index of the owner, zero-extended;
//              keeps its last value while no grant is held
//   gnt_valid  registered, high while a grant is held
//   timeout    registered single-cycle pulse, grant revoked by the hold limit
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int WIDTH_LOG = 2,
  parameter int MAX_HOLD  = 16,
  localparam int N        = 1 << WIDTH_LOG
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [7:0]     gnt_idx,
  output logic           gnt_valid,
  output logic           timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [N-1:0] ONE_HOT_BASE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [7:0]   HOLD_LIMIT   = 8'(MAX_HOLD);

  state_t                 state;
  logic [WIDTH_LOG-1:0]   ptr;
  logic [7:0]             hold_cnt;

  logic [WIDTH_LOG-1:0]   win_idx;
  logic                   win_found;
  logic [WIDTH_LOG-1:0]   cand;
  logic                   release_now;
  logic [WIDTH_LOG-1:0]   next_ptr;

  // Winner search, walking offsets from ptr downward so the smallest offset
  // is assigned last and wins. The sum wraps at N, which is exactly the
  // "first at or above ptr, otherwise first below ptr" order.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int j = N - 1; j >= 0; j--) begin
      cand = ptr + WIDTH_LOG'(j);
      if (req[cand]) begin
        win_idx   = cand;
        win_found = 1'b1;
      end
    end
  end

  // A grant ends on done or on reaching the hold limit. The pointer moves
  // one past the owner; the WIDTH_LOG-bit add gives the modular wrap.
  always_comb begin
    release_now = done || (hold_cnt == HOLD_LIMIT);
    next_ptr    = gnt_idx[WIDTH_LOG-1:0] + WIDTH_LOG'(1);
  end

  // Main FSM. A release always lands in IDLE, and IDLE only grants on the
  // following edge, so successive grants are always separated by one idle
  // cycle. Timeout defaults low every cycle so it can only ever be a
  // one-cycle pulse; when done and the hold limit coincide, done wins and
  // no pulse is raised.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= 8'd0;
      gnt       <= '0;
      gnt_idx   <= 8'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt       <= ONE_HOT_BASE << win_idx;
            gnt_idx   <= 8'(win_idx);
            gnt_valid <= 1'b1;
            hold_cnt  <= 8'd1;
            state     <= BUSY;
          end else begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
          end
        end
        BUSY: begin
          if (release_now) begin
            gnt       <= '0;
            gnt_valid <= 1'b0;
            ptr       <= next_ptr;
            hold_cnt  <= 8'd0;
            timeout   <= !done;
            state     <= IDLE;
          end else begin
            hold_cnt  <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
